// File: rtl/reg_dump_unit_pkg.sv
// Shared definitions for the register dump path.
// Defaults match the register file geometry.
package reg_dump_unit_pkg;

   localparam int DEF_REGF_WIDTH = 32;
   localparam int DEF_NUM_REGS   = 32;

   typedef enum logic [2:0] {
      IDLE,
      WAIT_HALT,
      READ,
      SEND,
      DONE
   } dump_state_t;

endpackage

// File: rtl/reg_dump_unit.sv
// Walks the register file after halt and streams every register
// out on a valid/ready channel for the debug/trace dump path.
module reg_dump_unit
   import reg_dump_unit_pkg::*;
#(
   parameter int REGF_WIDTH = DEF_REGF_WIDTH,
   parameter int NUM_REGS   = DEF_NUM_REGS,
   parameter int IDX_W      = $clog2(NUM_REGS)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  abort,
   input  logic                  halted,
   output logic [IDX_W-1:0]      rd_addr,
   input  logic [REGF_WIDTH-1:0] rd_data,
   output logic                  dout_valid,
   input  logic                  dout_ready,
   output logic [REGF_WIDTH-1:0] dout_data,
   output logic [IDX_W-1:0]      dout_idx,
   output logic                  dout_last,
   output logic                  busy,
   output logic                  done
);

   localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_REGS - 1);

   dump_state_t           state;
   logic [IDX_W-1:0]      idx;
   logic [REGF_WIDTH-1:0] data_q;

   assign rd_addr   = idx;
   assign dout_idx  = idx;
   assign dout_data = data_q;

   always_ff @(posedge clk) begin
      if (rst || abort) begin
         state      <= IDLE;
         idx        <= '0;
         data_q     <= '0;
         dout_valid <= 1'b0;
         dout_last  <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  idx   <= '0;
                  busy  <= 1'b1;
                  state <= halted ? READ : WAIT_HALT;
               end
            end
            WAIT_HALT: begin
               if (halted)
                  state <= READ;
            end
            READ: begin
               // x0 is architecturally zero whatever the array holds
               data_q     <= (idx == '0) ? '0 : rd_data;
               dout_valid <= 1'b1;
               dout_last  <= (idx == LAST);
               state      <= SEND;
            end
            SEND: begin
               if (dout_ready) begin
                  dout_valid <= 1'b0;
                  dout_last  <= 1'b0;
                  if (idx == LAST) begin
                     done  <= 1'b1;
                     state <= DONE;
                  end else begin
                     idx   <= idx + IDX_W'(1);
                     state <= READ;
                  end
               end
            end
            DONE: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               idx   <= '0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_reg_dump_unit.sv
// Directed bench: small regfile model feeding reg_dump_unit,
// immediate assertions on every checked value.
module tb_reg_dump_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        abort = 1'b0;
   logic        halted = 1'b0;
   logic [4:0]  rd_addr;
   logic [31:0] rd_data;
   logic        dout_valid;
   logic        dout_ready = 1'b0;
   logic [31:0] dout_data;
   logic [4:0]  dout_idx;
   logic        dout_last;
   logic        busy;
   logic        done;

   logic        we = 1'b0;
   logic [4:0]  wa = '0;
   logic [31:0] wd = '0;
   logic [31:0] rf [32];

   int n_asrt = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   // regfile: registered write port, combinational read port
   always @(posedge clk)
      if (we) rf[wa] <= wd;
   assign rd_data = rf[rd_addr];

   reg_dump_unit dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .abort      (abort),
      .halted     (halted),
      .rd_addr    (rd_addr),
      .rd_data    (rd_data),
      .dout_valid (dout_valid),
      .dout_ready (dout_ready),
      .dout_data  (dout_data),
      .dout_idx   (dout_idx),
      .dout_last  (dout_last),
      .busy       (busy),
      .done       (done)
   );

   function automatic logic [31:0] exp_val(input int i);
      case (i)
         0:       return 32'd0;
         3:       return 32'd99;
         5:       return 32'd12345;
         10:      return 32'd54321;
         default: return 32'h1000_0000 + 32'(i * 3);
      endcase
   endfunction

   function automatic logic [31:0] init_val(input int i);
      if (i == 0) return 32'hDEADBEEF;
      return exp_val(i);
   endfunction

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] want);
      n_asrt++;
      assert (got === want) else begin
         n_fail++;
         $error("FAIL %s: got %0h want %0h", tag, got, want);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input int a, input logic [31:0] d);
      we = 1'b1;
      wa = 5'(a);
      wd = d;
      step();
      we = 1'b0;
   endtask

   task automatic wait_beat(input int t);
      bit ok;
      ok = 1'b0;
      for (int k = 0; k < 200; k++) begin
         if (dout_valid && dout_idx == 5'(t)) begin
            ok = 1'b1;
            break;
         end
         step();
      end
      chk($sformatf("wait_beat%0d", t), 32'(ok), 32'd1);
   endtask

   initial begin
      int cyc, beats, dones, done_cyc, first_v;
      bit seq_ok, data_ok, last_ok, flag;
      logic [31:0] got [32];

      step();
      step();
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_valid", 32'(dout_valid), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_addr", 32'(rd_addr), 32'd0);
      chk("rst_data", dout_data, 32'd0);
      rst = 1'b0;

      for (int i = 0; i < 32; i++)
         wr(i, init_val(i));

      // full dump, ready tied high
      halted = 1'b1;
      dout_ready = 1'b1;
      start = 1'b1;
      step();
      start = 1'b0;
      cyc = 1; beats = 0; dones = 0; done_cyc = 0; first_v = 0;
      seq_ok = 1'b1; data_ok = 1'b1; last_ok = 1'b1;
      for (int k = 0; k < 100; k++) begin
         step();
         cyc++;
         if (dout_valid && first_v == 0) first_v = cyc;
         if (dout_valid && beats < 32) begin
            if (dout_idx != 5'(beats)) seq_ok = 1'b0;
            if (dout_data !== exp_val(beats)) data_ok = 1'b0;
            if (dout_last !== (beats == 31)) last_ok = 1'b0;
            got[beats] = dout_data;
            beats++;
         end
         if (done) begin
            dones++;
            done_cyc = cyc;
         end
      end
      chk("first_valid_cyc", 32'(first_v), 32'd2);
      chk("beats", 32'(beats), 32'd32);
      chk("x0_forced", got[0], 32'd0);
      chk("x5", got[5], 32'd12345);
      chk("x10", got[10], 32'd54321);
      chk("idx_seq", 32'(seq_ok), 32'd1);
      chk("data_all", 32'(data_ok), 32'd1);
      chk("last_flag", 32'(last_ok), 32'd1);
      chk("done_count", 32'(dones), 32'd1);
      chk("done_cyc", 32'(done_cyc), 32'd65);
      chk("idle_busy", 32'(busy), 32'd0);

      // start while not halted
      halted = 1'b0;
      start = 1'b1;
      step();
      start = 1'b0;
      flag = 1'b1;
      for (int k = 0; k < 7; k++) begin
         if (dout_valid || !busy) flag = 1'b0;
         step();
      end
      chk("wait_halt_quiet", 32'(flag), 32'd1);
      halted = 1'b1;
      step();
      chk("halt_rise_e1", 32'(dout_valid), 32'd0);
      step();
      chk("halt_rise_e2", 32'(dout_valid), 32'd1);
      chk("halt_rise_idx", 32'(dout_idx), 32'd0);

      // back-pressure on beat 5
      wait_beat(5);
      dout_ready = 1'b0;
      flag = 1'b1;
      for (int k = 0; k < 5; k++) begin
         step();
         if (!dout_valid || dout_idx != 5'd5 ||
             dout_data !== 32'd12345) flag = 1'b0;
      end
      chk("stall_hold", 32'(flag), 32'd1);
      dout_ready = 1'b1;
      step();
      chk("post_hs_valid", 32'(dout_valid), 32'd0);
      step();
      chk("next_idx", 32'(dout_idx), 32'd6);
      chk("next_valid", 32'(dout_valid), 32'd1);

      // abort mid-beat
      wait_beat(10);
      abort = 1'b1;
      step();
      abort = 1'b0;
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_valid", 32'(dout_valid), 32'd0);
      flag = 1'b1;
      for (int k = 0; k < 4; k++) begin
         if (done) flag = 1'b0;
         step();
      end
      chk("abort_no_done", 32'(flag), 32'd1);

      // restart, ignored start, reset mid-dump
      start = 1'b1;
      step();
      start = 1'b0;
      step();
      chk("restart_idx", 32'(dout_idx), 32'd0);
      chk("restart_data", dout_data, 32'd0);
      wait_beat(15);
      start = 1'b1;
      step();
      start = 1'b0;
      chk("start_busy_ign", 32'(dout_idx), 32'd16);
      wait_beat(20);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("mrst_busy", 32'(busy), 32'd0);
      chk("mrst_valid", 32'(dout_valid), 32'd0);
      chk("mrst_addr", 32'(rd_addr), 32'd0);
      chk("mrst_data", dout_data, 32'd0);
      chk("mrst_last", 32'(dout_last), 32'd0);
      chk("mrst_done", 32'(done), 32'd0);
      step();
      chk("mrst_idle", 32'(busy), 32'd0);

      // write-back collision while reading x3
      start = 1'b1;
      step();
      start = 1'b0;
      wait_beat(2);
      step();
      chk("read3_addr", 32'(rd_addr), 32'd3);
      we = 1'b1;
      wa = 5'd3;
      wd = 32'd7;
      step();
      we = 1'b0;
      chk("wb_idx", 32'(dout_idx), 32'd3);
      chk("wb_old_val", dout_data, 32'd99);
      dones = 0;
      last_ok = 1'b1;
      for (int k = 0; k < 80; k++) begin
         if (dout_valid && (dout_last !== (dout_idx == 5'd31)))
            last_ok = 1'b0;
         if (done) dones++;
         step();
      end
      chk("last_only_31", 32'(last_ok), 32'd1);
      chk("wb_done", 32'(dones), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_asrt, n_fail);
      $finish;
   end

endmodule
